maze_dfs_engine: RTL and testbench

Parametrised depth-first maze-solving engine for square grids of 2^COORD_W × 2^COORD_W cells. It supersedes the fixed 16×16 controller and adds:
- configurable source and destination cells;
- grid-edge detection, so moves never wrap around the grid;
- a memory req/ack handshake;
- backtracking that resumes at the next untried direction;
- an internal direction stack whose contents are replayed as the solved path.

It sits between the host start/status logic and the external cell memory, which holds one blocked/visited bit per cell.

---
 rtl/maze_dfs_engine.sv | 204 ++++++++++++++++++++
 tb/tb_maze_dfs_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_dfs_engine.sv
// Depth-first maze solver for a 2^COORD_W square grid: marks cells, probes neighbours, backtracks via a direction stack.
// Memory requests hold until mem_ack (zero-wait capable); in DONE the stack is replayed one beat per path_ready cycle.
module maze_dfs_engine #(
  parameter int COORD_W = 4,
  parameter int DEPTH   = 2 ** (2 * COORD_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*COORD_W-1:0]   src,
  input  logic [2*COORD_W-1:0]   dst,
  output logic [2*COORD_W-1:0]   mem_addr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  input  logic                   mem_rdata,
  input  logic                   mem_ack,
  output logic [2*COORD_W-1:0]   cur_loc,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic                   overflow,
  output logic                   path_valid,
  output logic [1:0]             path_dir,
  output logic                   path_last,
  input  logic                   path_ready
);
  localparam int LOC_W = 2 * COORD_W;
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_MARK, S_CHECK, S_PROBE, S_EVAL, S_NEXT, S_BACK, S_DONE, S_FAIL
  } state_t;

  state_t state, state_nxt;

  logic [LOC_W-1:0] cur, dst_q, nbr;
  logic [SP_W-1:0]  sp, idx;
  logic [1:0]       dir, top_d;
  logic             rdata_q, done_q, fail_q, ovf_q;
  logic [1:0]       stack [DEPTH];
  logic             off_grid, at_goal, stack_full, stack_empty, start_ok, beat;

  function automatic logic [LOC_W-1:0] step(input logic [LOC_W-1:0] loc, input logic [1:0] d);
    logic [COORD_W-1:0] r, c;
    r = loc[LOC_W-1:COORD_W];
    c = loc[COORD_W-1:0];
    case (d)
      2'd0:    c = c + COORD_W'(1);
      2'd1:    r = r + COORD_W'(1);
      2'd2:    c = c - COORD_W'(1);
      default: r = r - COORD_W'(1);
    endcase
    return {r, c};
  endfunction

  // A move off the grid edge must never wrap, so it is skipped before any memory access.
  always_comb begin
    off_grid = 1'b0;
    case (dir)
      2'd0:    off_grid = &cur[COORD_W-1:0];
      2'd1:    off_grid = &cur[LOC_W-1:COORD_W];
      2'd2:    off_grid = (cur[COORD_W-1:0] == '0);
      default: off_grid = (cur[LOC_W-1:COORD_W] == '0);
    endcase
  end

  assign nbr         = step(cur, dir);
  assign top_d       = stack[IDX_W'(sp - SP_W'(1))];
  assign at_goal     = (cur == dst_q);
  assign stack_full  = (sp == SP_W'(DEPTH));
  assign stack_empty = (sp == '0);
  assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
  assign beat        = path_valid && path_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MARK;
      S_MARK:  if (mem_ack) state_nxt = S_CHECK;
      S_CHECK: state_nxt = at_goal ? S_DONE : S_PROBE;
      S_PROBE: begin
        if (off_grid)     state_nxt = S_NEXT;
        else if (mem_ack) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (rdata_q)         state_nxt = S_NEXT;
        else if (stack_full) state_nxt = S_FAIL;
        else                 state_nxt = S_MARK;
      end
      S_NEXT:  state_nxt = (dir == 2'd3) ? S_BACK : S_PROBE;
      S_BACK: begin
        if (stack_empty)         state_nxt = S_FAIL;
        else if (top_d == 2'd3)  state_nxt = S_BACK;
        else                     state_nxt = S_PROBE;
      end
      S_DONE:  if (start) state_nxt = S_MARK;
      S_FAIL:  if (start) state_nxt = S_MARK;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= '0;
      dst_q   <= '0;
      sp      <= '0;
      idx     <= '0;
      dir     <= '0;
      rdata_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (start_ok) begin
      cur    <= src;
      dst_q  <= dst;
      sp     <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_CHECK: begin
          dir <= '0;
          if (at_goal) done_q <= 1'b1;
        end
        S_PROBE: if (!off_grid && mem_ack) rdata_q <= mem_rdata;
        S_EVAL: begin
          if (!rdata_q) begin
            if (stack_full) begin
              fail_q <= 1'b1;
              ovf_q  <= 1'b1;
            end else begin
              sp  <= sp + SP_W'(1);
              cur <= nbr;
            end
          end
        end
        S_NEXT: if (dir != 2'd3) dir <= dir + 2'd1;
        // Popping retraces the move and resumes at the next untried direction.
        S_BACK: begin
          if (stack_empty) begin
            fail_q <= 1'b1;
          end else begin
            sp  <= sp - SP_W'(1);
            cur <= step(cur, top_d ^ 2'd2);
            dir <= top_d + 2'd1;
          end
        end
        S_DONE: if (beat) idx <= idx + SP_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_EVAL) && !rdata_q && !stack_full)
      stack[IDX_W'(sp)] <= dir;
  end

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    busy       = 1'b1;
    path_valid = 1'b0;
    path_dir   = 2'd0;
    path_last  = 1'b0;
    case (state)
      S_MARK: begin
        mem_wr   = 1'b1;
        mem_addr = cur;
      end
      S_PROBE: begin
        if (!off_grid) begin
          mem_rd   = 1'b1;
          mem_addr = nbr;
        end
      end
      S_IDLE, S_FAIL: busy = 1'b0;
      S_DONE: begin
        busy       = 1'b0;
        path_valid = (idx < sp);
        if (idx < sp) begin
          path_dir  = stack[IDX_W'(idx)];
          path_last = (idx == sp - SP_W'(1));
        end
      end
      default: ;
    endcase
  end

  assign cur_loc  = cur;
  assign done     = done_q;
  assign fail     = fail_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_maze_dfs_engine.sv
// Randomized self-checking bench: memory responder with variable ack delay, DFS reference model, path replay checks.
module tb_maze_dfs_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] src = '0, dst = '0;
  logic       path_ready = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] a_addr, a_cur;
  logic       a_rd, a_wr, a_busy, a_done, a_fail, a_ovf, a_pv, a_pl, a_ack;
  logic [1:0] a_pd;
  logic [3:0] b_addr, b_cur;
  logic       b_rd, b_wr, b_busy, b_done, b_fail, b_ovf, b_pv, b_pl, b_ack;
  logic [1:0] b_pd;

  logic [7:0] m_addr, m_cur;
  logic       m_rd, m_wr, m_busy, m_done, m_fail, m_ovf, m_pv, m_pl, m_ack, m_rdata, req;
  logic [1:0] m_pd;

  logic wall [256];
  logic visited [256];

  maze_dfs_engine #(.COORD_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .src(src), .dst(dst),
    .mem_addr(a_addr), .mem_rd(a_rd), .mem_wr(a_wr), .mem_rdata(m_rdata), .mem_ack(a_ack),
    .cur_loc(a_cur), .busy(a_busy), .done(a_done), .fail(a_fail), .overflow(a_ovf),
    .path_valid(a_pv), .path_dir(a_pd), .path_last(a_pl), .path_ready(path_ready)
  );

  maze_dfs_engine #(.COORD_W(2), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .src(src[3:0]), .dst(dst[3:0]),
    .mem_addr(b_addr), .mem_rd(b_rd), .mem_wr(b_wr), .mem_rdata(m_rdata), .mem_ack(b_ack),
    .cur_loc(b_cur), .busy(b_busy), .done(b_done), .fail(b_fail), .overflow(b_ovf),
    .path_valid(b_pv), .path_dir(b_pd), .path_last(b_pl), .path_ready(path_ready)
  );

  assign m_addr  = sel ? {4'b0, b_addr} : a_addr;
  assign m_cur   = sel ? {4'b0, b_cur}  : a_cur;
  assign m_rd    = sel ? b_rd   : a_rd;
  assign m_wr    = sel ? b_wr   : a_wr;
  assign m_busy  = sel ? b_busy : a_busy;
  assign m_done  = sel ? b_done : a_done;
  assign m_fail  = sel ? b_fail : a_fail;
  assign m_ovf   = sel ? b_ovf  : a_ovf;
  assign m_pv    = sel ? b_pv   : a_pv;
  assign m_pd    = sel ? b_pd   : a_pd;
  assign m_pl    = sel ? b_pl   : a_pl;
  assign req     = m_rd | m_wr;
  assign m_rdata = wall[m_addr] | visited[m_addr];

  // Memory responder: per-request random wait, records every completed access.
  int         maxdly = 0;
  logic       clr = 1'b0, blk_rd = 1'b0;
  int         wcnt = 0, tr_n = 0, unstable = 0, both_cnt = 0;
  logic       pend = 1'b0, p_rd, p_wr;
  logic [7:0] p_addr;
  logic       tr_wr [4096];
  logic [7:0] tr_addr [4096];

  assign m_ack = req && (wcnt == 0) && !(blk_rd && m_rd);
  assign a_ack = sel ? 1'b0 : m_ack;
  assign b_ack = sel ? m_ack : 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) visited[i] <= 1'b0;
      tr_n <= 0; unstable <= 0; both_cnt <= 0; pend <= 1'b0; wcnt <= 0;
    end else begin
      if (pend && !rst && (m_addr != p_addr || m_rd != p_rd || m_wr != p_wr)) unstable <= unstable + 1;
      if (m_rd && m_wr) both_cnt <= both_cnt + 1;
      if (m_ack) begin
        if (tr_n < 4096) begin
          tr_wr[tr_n]   <= m_wr;
          tr_addr[tr_n] <= m_addr;
        end
        tr_n <= tr_n + 1;
        if (m_wr) visited[m_addr] <= 1'b1;
        wcnt <= int'($urandom_range(maxdly));
        pend <= 1'b0;
      end else if (req && !rst) begin
        pend <= 1'b1; p_addr <= m_addr; p_rd <= m_rd; p_wr <= m_wr;
        if (wcnt != 0) wcnt <= wcnt - 1;
      end else begin
        pend <= 1'b0;
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain DFS over the wall map producing the expected access list and path.
  int  exp_tr_addr [4096];
  bit  exp_tr_wr [4096];
  int  exp_n, exp_res;
  int  exp_path [$];
  int  got_path [$];
  int  last_cyc;

  function automatic int nb_of(input int cw, input int loc, input int d);
    int r, c;
    r = loc >> cw;
    c = loc & ((1 << cw) - 1);
    case (d)
      0: c = c + 1;
      1: r = r + 1;
      2: c = c - 1;
      default: r = r - 1;
    endcase
    return (r << cw) | c;
  endfunction

  task automatic tr_add(input bit w, input int a);
    exp_tr_wr[exp_n] = w;
    exp_tr_addr[exp_n] = a;
    exp_n++;
  endtask

  task automatic model_run(input int cw, input int depth, input int s, input int d);
    int mx, cur, dir, r, c, nb, pd;
    bit vis [256];
    int stk [$];
    bit fresh, off;
    for (int i = 0; i < 256; i++) vis[i] = 1'b0;
    mx = (1 << cw) - 1; cur = s; exp_n = 0; dir = 0;
    vis[cur] = 1'b1; tr_add(1'b1, cur); fresh = 1'b1;
    forever begin
      if (fresh) begin
        if (cur == d) begin exp_res = 0; break; end
        dir = 0; fresh = 1'b0;
      end
      if (dir > 3) begin
        if (stk.size() == 0) begin exp_res = 1; break; end
        pd = stk.pop_back();
        cur = nb_of(cw, cur, pd ^ 2);
        dir = pd + 1;
        continue;
      end
      r = cur >> cw; c = cur & mx;
      off = (dir == 0 && c == mx) || (dir == 1 && r == mx) || (dir == 2 && c == 0) || (dir == 3 && r == 0);
      if (off) begin dir++; continue; end
      nb = nb_of(cw, cur, dir);
      tr_add(1'b0, nb);
      if (wall[nb] || vis[nb]) begin dir++; continue; end
      if (stk.size() == depth) begin exp_res = 2; break; end
      stk.push_back(dir); cur = nb; vis[cur] = 1'b1; tr_add(1'b1, cur); fresh = 1'b1;
    end
    exp_path = stk;
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 256; i++) wall[i] = 1'b0;
  endtask

  function automatic int path_code();
    int v = 0;
    foreach (got_path[i]) v = v | (got_path[i] << (2 * i));
    return v;
  endfunction

  task automatic do_run(input bit use_b, input int s, input int d, input int dly, input string tag);
    int cyc, nbad, beats, lastbad, sz;
    sel = use_b; maxdly = dly;
    model_run(use_b ? 2 : 4, use_b ? 2 : 256, s, d);
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    src = 8'(s); dst = 8'(d); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (cyc = 1; cyc <= 30000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, ".busy_run"}, m_busy, 1);
      if (m_done || m_fail) break;
    end
    last_cyc = cyc;
    chk({tag, ".finished"}, m_done | m_fail, 1);
    chk({tag, ".done"}, m_done, exp_res == 0);
    chk({tag, ".fail"}, m_fail, exp_res != 0);
    chk({tag, ".overflow"}, m_ovf, exp_res == 2);
    chk({tag, ".busy_end"}, m_busy, 0);
    chk({tag, ".trace_len"}, tr_n, exp_n);
    nbad = 0;
    for (int i = 0; i < exp_n && i < tr_n && i < 4096; i++)
      if (tr_wr[i] !== exp_tr_wr[i] || int'(tr_addr[i]) != exp_tr_addr[i]) nbad++;
    chk({tag, ".trace_bad"}, nbad, 0);
    chk({tag, ".addr_unstable"}, unstable, 0);
    chk({tag, ".rd_wr_both"}, both_cnt, 0);
    sz = exp_path.size();
    got_path = {};
    beats = 0; nbad = 0; lastbad = 0;
    for (int k = 0; k < sz * 6 + 20; k++) begin
      @(posedge clk); #1 path_ready = 1'($urandom % 2);
      @(negedge clk);
      if (!m_pv && m_pl) lastbad++;
      if (m_pv && path_ready) begin
        got_path.push_back(int'(m_pd));
        if (beats >= sz || int'(m_pd) != exp_path[beats]) nbad++;
        if (m_pl != (beats == sz - 1)) lastbad++;
        beats++;
      end
    end
    path_ready = 1'b0;
    chk({tag, ".beats"}, beats, (exp_res == 0) ? sz : 0);
    chk({tag, ".path_bad"}, nbad, 0);
    chk({tag, ".last_bad"}, lastbad, 0);
  endtask

  initial begin
    int s, d, q0 [$], diffs;
    clear_walls();
    #2;
    chk("rst.busy", a_busy, 0);
    chk("rst.done", a_done, 0);
    chk("rst.fail", a_fail, 0);
    chk("rst.ovf", a_ovf, 0);
    chk("rst.rdwr", {a_rd, a_wr, b_rd, b_wr}, 0);
    chk("rst.addr", a_addr, 0);
    chk("rst.cur", a_cur, 0);
    chk("rst.pv", {a_pv, a_pl, b_pv}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Open 4x4 region carved out of the 16x16 grid
    for (int i = 0; i < 4; i++) begin wall[(i << 4) | 4] = 1'b1; wall[(4 << 4) | i] = 1'b1; end
    do_run(1'b0, 'h00, 'h33, 0, "open");
    chk("open.path", path_code(), 'h540);

    do_run(1'b0, 'h55, 'h55, 0, "same");
    chk("same.latency", last_cyc, 3);
    chk("same.writes", tr_n, 1);
    chk("same.addr", tr_addr[0], 'h55);

    clear_walls();
    wall['h01] = 1'b1; wall['h10] = 1'b1;
    do_run(1'b0, 'h00, 'hff, 0, "boxed");
    chk("boxed.accesses", tr_n, 3);

    clear_walls();
    wall['h03] = 1'b1; wall['h11] = 1'b1; wall['h12] = 1'b1;
    do_run(1'b0, 'h00, 'h20, 0, "deadend");
    chk("deadend.path", path_code(), 5);
    do_run(1'b0, 'h00, 'h20, 3, "deadend_dly");

    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 256; i++) wall[i] = ($urandom_range(99) < 28);
      s = int'($urandom_range(255)); d = int'($urandom_range(255));
      wall[s] = 1'b0; wall[d] = 1'b0;
      do_run(1'b0, s, d, 0, "rand0");
      q0 = got_path;
      do_run(1'b0, s, d, 3, "rand3");
      diffs = (q0.size() != got_path.size()) ? 1 : 0;
      for (int i = 0; i < q0.size() && i < got_path.size(); i++) if (q0[i] != got_path[i]) diffs++;
      chk("rand.same_path", diffs, 0);
    end

    // Abort a run while a read is outstanding
    clear_walls();
    blk_rd = 1'b1;
    sel = 1'b0; clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    src = 8'h00; dst = 8'h33; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_rd) break;
    end
    chk("abort.rd_pending", a_rd, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort.rd", a_rd, 0);
    chk("abort.wr", a_wr, 0);
    chk("abort.addr", a_addr, 0);
    chk("abort.cur", a_cur, 0);
    chk("abort.flags", {a_busy, a_done, a_fail, a_ovf, a_pv, a_pl}, 0);
    @(posedge clk); #1 rst = 1'b0; blk_rd = 1'b0;
    do_run(1'b0, 'h00, 'h33, 0, "after_abort");

    clear_walls();
    do_run(1'b1, 'h0, 'h3, 0, "depth2");
    chk("depth2.ovf", b_ovf, 1);
    chk("depth2.accesses", tr_n, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
